// File: rtl/life_gen_sched_pkg.sv
// Shared types and constants for the generation scheduler: pixel counters,
// speed/period encoding, scheduler states and the clear-sweep address type.
package life_gen_sched_pkg;

  localparam int SCREEN_WIDTH  = 256;
  localparam int LOG_MAX_SPEED = 7;
  localparam int MAX_SPEED     = 2 ** LOG_MAX_SPEED;
  localparam int CELL_ADDR_W   = 12;

  typedef logic [10:0]              hcount_t;
  typedef logic [9:0]               vcount_t;
  typedef logic [LOG_MAX_SPEED-1:0] speed_t;
  typedef logic [LOG_MAX_SPEED:0]   period_t;
  typedef logic [CELL_ADDR_W-1:0]   cell_addr_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT     = 3'd1,
    STEP_ARM = 3'd2,
    COMPUTE  = 3'd3,
    CLEAR    = 3'd4
  } sched_state_t;

  // Frames per generation: speed 0 is MAX_SPEED frames, the top speed is 1 frame.
  function automatic period_t speed_to_period(input speed_t speed);
    return period_t'(MAX_SPEED) - period_t'(speed);
  endfunction

endpackage

// File: rtl/life_gen_sched_if.sv
// Control bundle between user-input decode, the scheduler and life_logic/cell RAM.
// Still-board detection ports exist only with LIFE_SCHED_STILL_PAUSE_EN defined.
interface life_gen_sched_if #(
  parameter int ADDR_W = 12,
  parameter int GEN_W  = 16
);
  import life_gen_sched_pkg::*;

  hcount_t           hcount_in;
  vcount_t           vcount_in;
  speed_t            speed_in;
  logic              pause_in;
  logic              step_in;
  logic              clear_in;
  logic              gen_en_out;
  logic              rd_bank_out;
  logic              clear_busy_out;
  logic              clear_wr_out;
  logic [ADDR_W-1:0] clear_addr_out;
  logic [GEN_W-1:0]  gen_count_out;
`ifdef LIFE_SCHED_STILL_PAUSE_EN
  logic              cell_changed_in;
  logic              still_out;
`endif

  modport master (
`ifdef LIFE_SCHED_STILL_PAUSE_EN
    output cell_changed_in,
    input  still_out,
`endif
    output hcount_in, vcount_in, speed_in, pause_in, step_in, clear_in,
    input  gen_en_out, rd_bank_out, clear_busy_out, clear_wr_out,
    input  clear_addr_out, gen_count_out
  );

  modport slave (
`ifdef LIFE_SCHED_STILL_PAUSE_EN
    input  cell_changed_in,
    output still_out,
`endif
    input  hcount_in, vcount_in, speed_in, pause_in, step_in, clear_in,
    output gen_en_out, rd_bank_out, clear_busy_out, clear_wr_out,
    output clear_addr_out, gen_count_out
  );

endinterface

// File: rtl/life_gen_sched_frame_divider.sv
// Frame-end detection and the per-generation frame counter; fire marks the
// frame_end at which the current period has elapsed.
module life_gen_sched_frame_divider
  import life_gen_sched_pkg::*;
#(
  parameter int H_LAST = SCREEN_WIDTH + 4,
  parameter int V_LAST = SCREEN_WIDTH + 4
) (
  input  logic    clk_in,
  input  logic    rst_in,
  input  hcount_t hcount_in,
  input  vcount_t vcount_in,
  input  speed_t  speed_in,
  input  logic    count_en_in,
  input  logic    hold_in,
  output logic    frame_end_out,
  output logic    fire_out
);

  period_t frame_cnt_r;
  period_t frame_cnt_s;
  period_t period_s;
  logic    frame_end_s;
  logic    fire_s;

  // The compute frame counts as frame 0 of its period, so counting spans WAIT and COMPUTE.
  always_comb begin
    frame_end_s = (hcount_in == hcount_t'(H_LAST)) && (vcount_in == vcount_t'(V_LAST));
    period_s    = speed_to_period(speed_in);
    fire_s      = frame_end_s && count_en_in && (frame_cnt_r >= (period_s - period_t'(1)));
    if (hold_in) begin
      frame_cnt_s = '0;
    end else if (fire_s) begin
      frame_cnt_s = '0;
    end else if (frame_end_s && count_en_in) begin
      frame_cnt_s = frame_cnt_r + period_t'(1);
    end else begin
      frame_cnt_s = frame_cnt_r;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frame_cnt_r <= '0;
    end else begin
      frame_cnt_r <= frame_cnt_s;
    end
  end

  assign frame_end_out = frame_end_s;
  assign fire_out      = fire_s;

endmodule

// File: rtl/life_gen_sched.sv
// Generation scheduler: run/pause/step/clear control and bank swapping for life_logic.
// Optional still-board auto-pause is enabled by defining LIFE_SCHED_STILL_PAUSE_EN.
module life_gen_sched
  import life_gen_sched_pkg::*;
#(
  parameter int H_LAST    = SCREEN_WIDTH + 4,
  parameter int V_LAST    = SCREEN_WIDTH + 4,
  parameter int NUM_CELLS = 4096,
  parameter int ADDR_W    = 12,
  parameter int GEN_W     = 16
) (
  input logic             clk_in,
  input logic             rst_in,
  life_gen_sched_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CELLS - 1);

  sched_state_t      state_r;
  sched_state_t      state_s;
  logic              one_shot_r;
  logic              one_shot_s;
  logic              gen_en_r;
  logic              gen_en_s;
  logic              rd_bank_r;
  logic              rd_bank_s;
  logic              clear_act_r;
  logic              clear_act_s;
  logic [ADDR_W-1:0] clear_addr_r;
  logic [ADDR_W-1:0] clear_addr_s;
  logic [GEN_W-1:0]  gen_count_r;
  logic [GEN_W-1:0]  gen_count_s;
  logic              frame_end_s;
  logic              fire_s;
  logic              swap_s;
  logic              clear_req_s;
  logic              still_hit_s;
  logic              idle_hold_s;
  logic              still_gate_s;

  life_gen_sched_frame_divider #(
    .H_LAST (H_LAST),
    .V_LAST (V_LAST)
  ) u_frame_divider (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .hcount_in     (bus.hcount_in),
    .vcount_in     (bus.vcount_in),
    .speed_in      (bus.speed_in),
    .count_en_in   ((state_r == WAIT) || (state_r == COMPUTE)),
    .hold_in       (state_r == IDLE),
    .frame_end_out (frame_end_s),
    .fire_out      (fire_s)
  );

`ifdef LIFE_SCHED_STILL_PAUSE_EN
  logic changed_r;
  logic still_r;
  logic pause_d_r;

  assign still_hit_s  = !(changed_r || bus.cell_changed_in);
  assign idle_hold_s  = still_r && !(bus.step_in || (bus.pause_in && !pause_d_r));
  assign still_gate_s = still_r;
  assign bus.still_out = still_r;

  // Sticky change flag per generation, still latch and pause edge history.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      changed_r <= 1'b0;
      still_r   <= 1'b0;
      pause_d_r <= 1'b0;
    end else begin
      pause_d_r <= bus.pause_in;
      if ((state_s == COMPUTE) && ((state_r != COMPUTE) || swap_s)) begin
        changed_r <= 1'b0;
      end else if (bus.cell_changed_in) begin
        changed_r <= 1'b1;
      end else begin
        changed_r <= changed_r;
      end
      if (clear_req_s) begin
        still_r <= 1'b0;
      end else if (swap_s && still_hit_s) begin
        still_r <= 1'b1;
      end else if ((state_r == IDLE) && !idle_hold_s) begin
        still_r <= 1'b0;
      end else begin
        still_r <= still_r;
      end
    end
  end
`else
  assign still_hit_s  = 1'b0;
  assign idle_hold_s  = 1'b0;
  assign still_gate_s = 1'b0;
`endif

  // State register plus the registered outputs computed from the next state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r      <= IDLE;
      one_shot_r   <= 1'b0;
      gen_en_r     <= 1'b0;
      rd_bank_r    <= 1'b0;
      clear_act_r  <= 1'b0;
      clear_addr_r <= '0;
      gen_count_r  <= '0;
    end else begin
      state_r      <= state_s;
      one_shot_r   <= one_shot_s;
      gen_en_r     <= gen_en_s;
      rd_bank_r    <= rd_bank_s;
      clear_act_r  <= clear_act_s;
      clear_addr_r <= clear_addr_s;
      gen_count_r  <= gen_count_s;
    end
  end

  // Next-state logic; clear pre-empts everything except a sweep already running.
  always_comb begin
    state_s     = state_r;
    one_shot_s  = one_shot_r;
    swap_s      = 1'b0;
    clear_req_s = bus.clear_in && (state_r != CLEAR);
    if (clear_req_s) begin
      state_s    = CLEAR;
      one_shot_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (idle_hold_s) begin
            state_s = IDLE;
          end else if (bus.step_in && (bus.pause_in || still_gate_s)) begin
            state_s = STEP_ARM;
          end else if (!bus.pause_in) begin
            state_s = WAIT;
          end else begin
            state_s = IDLE;
          end
        end
        WAIT: begin
          if (bus.pause_in) begin
            state_s = IDLE;
          end else if (fire_s) begin
            state_s = COMPUTE;
          end else begin
            state_s = WAIT;
          end
        end
        STEP_ARM: begin
          if (frame_end_s) begin
            state_s    = COMPUTE;
            one_shot_s = 1'b1;
          end else begin
            state_s = STEP_ARM;
          end
        end
        COMPUTE: begin
          if (frame_end_s) begin
            swap_s = 1'b1;
            if (one_shot_r || bus.pause_in || still_hit_s) begin
              state_s    = IDLE;
              one_shot_s = 1'b0;
            end else if (fire_s) begin
              state_s = COMPUTE;
            end else begin
              state_s = WAIT;
            end
          end else begin
            state_s = COMPUTE;
          end
        end
        CLEAR: begin
          if (clear_addr_r == LAST_ADDR) begin
            state_s = IDLE;
          end else begin
            state_s = CLEAR;
          end
        end
        default: begin
          state_s    = IDLE;
          one_shot_s = 1'b0;
        end
      endcase
    end
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    gen_en_s    = (state_s == COMPUTE);
    clear_act_s = (state_s == CLEAR);
    rd_bank_s   = rd_bank_r ^ swap_s;
    if (swap_s) begin
      gen_count_s = gen_count_r + GEN_W'(1);
    end else begin
      gen_count_s = gen_count_r;
    end
    if ((state_r == CLEAR) && (state_s == CLEAR)) begin
      clear_addr_s = clear_addr_r + ADDR_W'(1);
    end else begin
      clear_addr_s = '0;
    end
  end

  assign bus.gen_en_out     = gen_en_r;
  assign bus.rd_bank_out    = rd_bank_r;
  assign bus.clear_busy_out = clear_act_r;
  assign bus.clear_wr_out   = clear_act_r;
  assign bus.clear_addr_out = clear_addr_r;
  assign bus.gen_count_out  = gen_count_r;

endmodule

// File: tb/tb_life_gen_sched.sv
// Directed bench for life_gen_sched on a shrunken 8x4 pixel frame with a 16-cell clear sweep.
module tb_life_gen_sched;
  import life_gen_sched_pkg::*;

  localparam int HL    = 7;
  localparam int VL    = 3;
  localparam int NC    = 16;
  localparam int AW    = 4;
  localparam int GW    = 16;
  localparam int FRAME = (HL + 1) * (VL + 1);

  typedef struct {
    logic   ps;
    logic   pm;
    speed_t spd;
    logic   st;
    logic   full;
    logic   bank;
    int     cnt;
  } frame_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  frame_vec_t vecs[$];

  life_gen_sched_if #(.ADDR_W(AW), .GEN_W(GW)) bus();

  life_gen_sched #(
    .H_LAST    (HL),
    .V_LAST    (VL),
    .NUM_CELLS (NC),
    .ADDR_W    (AW),
    .GEN_W     (GW)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.hcount_in == hcount_t'(HL)) begin
      bus.hcount_in = '0;
      if (bus.vcount_in == vcount_t'(VL)) bus.vcount_in = '0;
      else bus.vcount_in = bus.vcount_in + vcount_t'(1);
    end else begin
      bus.hcount_in = bus.hcount_in + hcount_t'(1);
    end
  endtask

  task automatic sync_frame(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!((bus.hcount_in == '0) && (bus.vcount_in == '0)) && (n < 2 * FRAME));
    check(name, ((bus.hcount_in == '0) && (bus.vcount_in == '0)), 1);
  endtask

  task automatic add_vec(input logic ps, input logic pm, input int spd, input logic st,
                         input logic full, input logic bank, input int cnt);
    frame_vec_t v;
    v.ps = ps; v.pm = pm; v.spd = speed_t'(spd); v.st = st;
    v.full = full; v.bank = bank; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    int busy;
    bus.hcount_in = '0;
    bus.vcount_in = '0;
    bus.speed_in  = speed_t'(127);
    bus.pause_in  = 1'b0;
    bus.step_in   = 1'b0;
    bus.clear_in  = 1'b0;

    // ps pm speed step | full-frame gen_en, bank and count after the frame
    add_vec(1'b0, 1'b0, 127, 1'b0, 1'b1, 1'b1, 1);
    add_vec(1'b0, 1'b0, 127, 1'b0, 1'b1, 1'b0, 2);
    add_vec(1'b0, 1'b0, 127, 1'b0, 1'b1, 1'b1, 3);
    add_vec(1'b0, 1'b0, 125, 1'b0, 1'b1, 1'b0, 4);
    add_vec(1'b0, 1'b0, 125, 1'b0, 1'b0, 1'b0, 4);
    add_vec(1'b0, 1'b0, 125, 1'b0, 1'b0, 1'b0, 4);
    add_vec(1'b0, 1'b0, 125, 1'b0, 1'b1, 1'b1, 5);
    add_vec(1'b0, 1'b0, 125, 1'b1, 1'b0, 1'b1, 5);
    add_vec(1'b0, 1'b0, 125, 1'b0, 1'b0, 1'b1, 5);
    add_vec(1'b0, 1'b0, 125, 1'b0, 1'b1, 1'b0, 6);
    add_vec(1'b1, 1'b1, 125, 1'b0, 1'b0, 1'b0, 6);
    add_vec(1'b1, 1'b1, 125, 1'b1, 1'b0, 1'b0, 6);
    add_vec(1'b1, 1'b1, 125, 1'b0, 1'b1, 1'b1, 7);
    add_vec(1'b1, 1'b1, 125, 1'b0, 1'b0, 1'b1, 7);
    add_vec(1'b0, 1'b0, 127, 1'b0, 1'b0, 1'b1, 7);
    add_vec(1'b0, 1'b1, 127, 1'b0, 1'b1, 1'b0, 8);
    add_vec(1'b1, 1'b1, 127, 1'b0, 1'b0, 1'b0, 8);
    add_vec(1'b0, 1'b0, 127, 1'b0, 1'b0, 1'b0, 8);

    repeat (3) tick();
    check("reset gen_en", bus.gen_en_out, 0);
    check("reset rd_bank", bus.rd_bank_out, 0);
    check("reset clear_busy", bus.clear_busy_out, 0);
    check("reset clear_wr", bus.clear_wr_out, 0);
    check("reset clear_addr", bus.clear_addr_out, 0);
    check("reset gen_count", bus.gen_count_out, 0);

    rst = 1'b0;
    sync_frame("first frame start");
    check("gen_en at first (0,0)", bus.gen_en_out, 1);

    foreach (vecs[i]) begin
      hi = 0;
      bus.pause_in = vecs[i].ps;
      bus.speed_in = vecs[i].spd;
      for (int k = 0; k < FRAME; k++) begin
        if (k == 10) begin
          bus.pause_in = vecs[i].pm;
          bus.step_in  = vecs[i].st;
        end
        if (k == 11) bus.step_in = 1'b0;
        hi += int'(bus.gen_en_out);
        tick();
      end
      check($sformatf("row%0d gen_en cycles", i), hi, vecs[i].full ? FRAME : 0);
      check($sformatf("row%0d rd_bank", i), bus.rd_bank_out, vecs[i].bank);
      check($sformatf("row%0d gen_count", i), bus.gen_count_out, vecs[i].cnt);
    end

    // Clear in the middle of a generation aborts it; a second clear mid-sweep is ignored.
    bus.pause_in = 1'b0;
    repeat (10) tick();
    check("gen_en before clear", bus.gen_en_out, 1);
    bus.clear_in = 1'b1;
    tick();
    bus.clear_in = 1'b0;
    check("gen_en after clear", bus.gen_en_out, 0);
    check("clear_busy start", bus.clear_busy_out, 1);
    for (int a = 0; a < NC; a++) begin
      check($sformatf("clear_addr step %0d", a), bus.clear_addr_out, a);
      check($sformatf("clear_wr step %0d", a), bus.clear_wr_out, 1);
      if (a == 5) bus.clear_in = 1'b1;
      tick();
      bus.clear_in = 1'b0;
    end
    check("clear_wr after sweep", bus.clear_wr_out, 0);
    check("clear_busy after sweep", bus.clear_busy_out, 0);
    check("rd_bank after clear", bus.rd_bank_out, 0);
    check("gen_count after clear", bus.gen_count_out, 8);

    // Clear and step together while paused: sweep only, no generation afterwards.
    bus.pause_in = 1'b1;
    tick();
    bus.step_in  = 1'b1;
    bus.clear_in = 1'b1;
    tick();
    bus.step_in  = 1'b0;
    bus.clear_in = 1'b0;
    check("step+clear addr", bus.clear_addr_out, 0);
    hi = 0;
    busy = 0;
    for (int k = 0; k < NC + 2 * FRAME; k++) begin
      hi   += int'(bus.gen_en_out);
      busy += int'(bus.clear_busy_out);
      tick();
    end
    check("step+clear busy cycles", busy, NC);
    check("step+clear gen_en cycles", hi, 0);
    check("step+clear gen_count", bus.gen_count_out, 8);
    check("step+clear rd_bank", bus.rd_bank_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_gen_sched.md
Name: life_gen_sched

Overview:
- Generation scheduler for life_logic and its double-banked cell memory.
- Decides, on frame boundaries, when life_logic computes the next generation (gen_en), which bank is read and which is written, and when banks swap.
- Also implements run/pause, single-step, and a full-board clear sweep.
- Sits between user-input decode (pause/step/clear/speed) and life_logic plus cell RAM; runs on the pixel clock.

Parameters:
- H_LAST, SCREEN_WIDTH+4: final hcount value of a line.
- V_LAST, SCREEN_WIDTH+4: final vcount value of a frame.
- NUM_CELLS, 4096: cells per bank; clear sweep length.
- ADDR_W, 12: clear address width; NUM_CELLS <= 2**ADDR_W.
- GEN_W, 16: generation counter width.

Ports:
- clk_in  in  1  pixel clock
- rst_in  in  1  synchronous active-high reset
- hcount_in  in  hcount_t  current pixel column
- vcount_in  in  vcount_t  current pixel row
- speed_in  in  LOG_MAX_SPEED  0 = slowest, 2**LOG_MAX_SPEED-1 = fastest
- pause_in  in  1  level; high = paused
- step_in  in  1  one-cycle pulse; single generation while paused
- clear_in  in  1  one-cycle pulse; zero both banks
- gen_en_out  out  1  life_logic computes and writes the next generation this frame
- rd_bank_out  out  1  bank life_logic reads; wr_bank = ~rd_bank_out
- clear_busy_out  out  1  clear sweep active
- clear_wr_out  out  1  write 0 to both banks at clear_addr_out
- clear_addr_out  out  ADDR_W  clear sweep address
- gen_count_out  out  GEN_W  completed generations, wraps

Behaviour:
- frame_end is a combinational pulse: hcount_in==H_LAST && vcount_in==V_LAST. All generation transitions occur on frame_end.
- Registered outputs take effect on the next cycle, i.e. at pixel (0,0).
- period = 2**LOG_MAX_SPEED - speed_in, held in LOG_MAX_SPEED+1 bits. speed_in is sampled at each frame_end.
- Reset: state IDLE, all outputs 0, frame_cnt 0.
- States:
  - IDLE:
    - pause_in=0 -> WAIT, frame_cnt=0.
    - pause_in=1 && step_in -> STEP_ARM.
  - WAIT:
    - pause_in=1 -> IDLE immediately.
    - On frame_end: if frame_cnt >= period-1 -> COMPUTE with frame_cnt=0; else frame_cnt++.
  - STEP_ARM:
    - On frame_end -> COMPUTE, with a one-shot flag set.
  - COMPUTE:
    - gen_en_out=1 for exactly one full frame.
    - At the next frame_end: rd_bank_out toggles and gen_count_out++.
    - Next state: one-shot or pause_in=1 -> IDLE; period==1 -> COMPUTE again (back-to-back, no gap); else WAIT.
    - A generation in progress is never aborted by pause.
  - CLEAR:
    - clear_wr_out=1 and clear_addr_out counts 0..NUM_CELLS-1, one per cycle.
    - clear_busy_out=1 and gen_en_out=0.
    - After the last address -> IDLE. Bank and gen_count_out are unchanged.
- clear_in has highest priority from any state except CLEAR, where it is ignored.
  - Clear during COMPUTE aborts the generation: no bank swap, no count increment.
- step_in is ignored outside IDLE-with-pause, and is dropped if coincident with clear_in.
- A speed_in change takes effect at the next frame_end comparison. frame_cnt is not reset on a speed change.

Optional Feature:
- Macro LIFE_SCHED_STILL_PAUSE_EN.
- With the macro defined:
  - Adds input cell_changed_in (1 bit, pulse from life_logic when a written cell differs from its old value) and output still_out (1 bit).
  - A sticky flag is cleared when COMPUTE is entered and set by cell_changed_in.
  - If the flag is 0 at the COMPUTE-ending frame_end: swap still occurs, then the state forces IDLE and still_out=1, even with pause_in=0.
  - still_out clears, and the state may leave IDLE, only on step_in, clear_in, or a pause_in rising edge.
- Without the macro: neither port exists and the behaviour above is unconditional.

Decomposition:
- common package gains:
  - sched_state_t enum (IDLE, WAIT, STEP_ARM, COMPUTE, CLEAR).
  - MAX_SPEED = 2**LOG_MAX_SPEED.
  - cell_addr_t.
- hcount_t, vcount_t and LOG_MAX_SPEED are reused from the package.
- One sub-module, frame_divider: frame_end detection plus the period counter, with a "fire" output.

Test Plan:
- Reset with pause_in=0, speed_in=127 (LOG_MAX_SPEED=7):
  - From the first frame_end after reset, gen_en_out is high continuously.
  - rd_bank_out toggles at every frame_end; gen_count_out = 3 after 3 computed frames.
- speed_in=125 (period 3):
  - Exactly 1 of every 3 frames has gen_en_out=1; the other 2 frames are low.
- pause_in=1, step_in pulse mid-frame:
  - gen_en_out rises at the next (0,0), lasts one frame, then stays low.
  - rd_bank_out toggles once; gen_count_out increments by 1.
- pause_in raised mid-COMPUTE:
  - gen_en_out stays high until that frame_end and the swap occurs, then IDLE.
- clear_in mid-COMPUTE with NUM_CELLS=16:
  - gen_en_out drops the next cycle; clear_addr_out steps 0..15 with clear_wr_out=1 for 16 cycles.
  - rd_bank_out and gen_count_out are unchanged.
- clear_in and step_in in the same cycle:
  - The clear sweep runs; no generation follows; the state returns to IDLE.
